// File: rtl/ece178_nios_20_1_sw_edge_capture.sv
// Purpose: Avalon-MM input PIO; sync, debounce, edge-capture of WIDTH inputs with maskable level irq.
// Latency: in_port->data SYNC_STAGES+DEBOUNCE_CYCLES+1 .. SYNC_STAGES+2*DEBOUNCE_CYCLES+1 clk; readdata combinational.
// Backpressure: none; zero-wait-state slave, every access completes in the cycle it is presented.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   address    word address into the 4-word register window
//   chipselect slave select (qualifies writes only; reads ignore it)
//   write_n    active-low write strobe
//   writedata  32-bit write data
//   readdata   32-bit read data, combinational from address
//   in_port    asynchronous external inputs (switches / keys)
//   irq        active-high level interrupt = |(capture & mask)
//
// Register map: 0 data (debounced, RO), 1 reserved (reads 0), 2 irqmask (RW), 3 capture (RO, W1C).

`timescale 1ns/1ps

module ece178_nios_20_1_sw_edge_capture #(
    parameter int          WIDTH           = 18,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          EDGE_TYPE       = 0,
    parameter logic [31:0] RESET_MASK      = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE = 2'd3;

    // ------------------------------------------------------------------
    // Synchroniser: stage 0 takes the raw pin, the last stage feeds logic.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce. A shared free-running counter produces one tick every
    // DEBOUNCE_CYCLES clocks. A bit is accepted only when the synchronised
    // level matches the level sampled on the previous tick, so a level has
    // to survive across two consecutive ticks; anything shorter than one
    // tick period can never be seen twice.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] deb;

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (reset) begin
                    deb <= '0;
                end else begin
                    deb <= sync;
                end
            end
        end else begin : g_debounce
            localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt;
            logic             tick;
            logic [WIDTH-1:0] sample;
            logic [WIDTH-1:0] stable;

            assign tick   = (cnt == CNT_MAX);
            // Bits whose level agrees with the previous tick's sample.
            assign stable = ~(sync ^ sample);

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt    <= '0;
                    sample <= '0;
                    deb    <= '0;
                end else begin
                    if (tick) begin
                        cnt    <= '0;
                        sample <= sync;
                        deb    <= (sync & stable) | (deb & ~stable);
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge detection against the previous cycle's debounced value.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_d <= '0;
        end else begin
            deb_d <= deb;
        end
    end

    assign rise     = deb & ~deb_d;
    assign fall     = ~deb & deb_d;
    assign edge_evt = (EDGE_TYPE == 0) ? rise :
                      (EDGE_TYPE == 1) ? fall :
                                         (rise | fall);

    // ------------------------------------------------------------------
    // Register writes. Mask and capture sit at different addresses, so a
    // single access can never touch both.
    // ------------------------------------------------------------------
    logic             wr_en;
    logic             mask_wr;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] capture;

    assign wr_en   = chipselect & ~write_n;
    assign mask_wr = wr_en && (address == ADDR_IRQMASK);
    assign cap_clr = (wr_en && (address == ADDR_CAPTURE)) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= RESET_MASK[WIDTH-1:0];
        end else if (mask_wr) begin
            mask <= writedata[WIDTH-1:0];
        end
    end

    // Event is OR'd in after the clear so a same-cycle event always wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            capture <= '0;
        end else begin
            capture <= (capture & ~cap_clr) | edge_evt;
        end
    end

    assign irq = |(capture & mask);

    // ------------------------------------------------------------------
    // Read mux: zero-extended, independent of chipselect.
    // ------------------------------------------------------------------
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = deb;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = mask;
            ADDR_CAPTURE: readdata[WIDTH-1:0] = capture;
            default:      readdata = '0;
        endcase
    end

    // Upper writedata bits are architecturally ignored when WIDTH < 32.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_ece178_nios_20_1_sw_edge_capture.sv
`timescale 1ns/1ps

module tb_ece178_nios_20_1_sw_edge_capture;

    localparam int W = 18;
    localparam logic [31:0] ALL = 32'h3FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rdata [3];
    logic [2:0]    irq_v;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: accepted input value, mask, capture per edge type.
    logic [W-1:0]  exp_deb;
    logic [W-1:0]  exp_mask;
    logic [W-1:0]  exp_cap [3];

    always #5 clk = ~clk;

    ece178_nios_20_1_sw_edge_capture #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE(0), .RESET_MASK(32'h0)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdata[0]),
        .in_port(in_port), .irq(irq_v[0]));

    ece178_nios_20_1_sw_edge_capture #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE(1), .RESET_MASK(32'h0)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdata[1]),
        .in_port(in_port), .irq(irq_v[1]));

    ece178_nios_20_1_sw_edge_capture #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE(2), .RESET_MASK(32'h0)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdata[2]),
        .in_port(in_port), .irq(irq_v[2]));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_port = '0; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = 32'h0;
        step(3);
        reset = 1'b0;
        step(1);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (rdata[k] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL reset_read inst%0d addr%0d: got %h want 00000000", k, a, rdata[k]);
                end
            end
        end
        n_checks++;
        if (irq_v !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_irq: got %b want 000", irq_v);
        end
    endtask

    task automatic test_rise_detect;
        int cyc = 0;
        bit got = 0;
        in_port = W'(1);
        for (int i = 1; i <= 11 && !got; i++) begin
            step(1);
            rd(2'd0);
            if (rdata[0][0]) begin
                got = 1;
                cyc = i;
            end
        end
        n_checks++;
        if (rdata[0] !== 32'h1) begin
            n_fail++;
            $display("FAIL rise_data_within_11: got %h want 00000001", rdata[0]);
        end
        n_checks++;
        if (cyc < 7) begin
            n_fail++;
            $display("FAIL rise_latency_min: got %0d cycles want >= 7", cyc);
        end
        step(1);
        rd(2'd3);
        n_checks++;
        if (rdata[0] !== 32'h1) begin
            n_fail++;
            $display("FAIL rise_capture: got %h want 00000001", rdata[0]);
        end
        n_checks++;
        if (irq_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_irq_masked: got %b want 0", irq_v[0]);
        end
        wr(2'd2, 32'h1);
        n_checks++;
        if (irq_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rise_irq_unmasked: got %b want 1", irq_v[0]);
        end
        rd(2'd2);
        n_checks++;
        if (rdata[0] !== 32'h1) begin
            n_fail++;
            $display("FAIL rise_mask_read: got %h want 00000001", rdata[0]);
        end
    endtask

    task automatic test_glitch;
        wr(2'd3, ALL);
        in_port = W'(32'h9);
        step(3);
        in_port = W'(32'h1);
        step(20);
        for (int k = 0; k < 3; k++) begin
            rd(2'd0);
            n_checks++;
            if (rdata[k] !== 32'h1) begin
                n_fail++;
                $display("FAIL glitch_data inst%0d: got %h want 00000001", k, rdata[k]);
            end
            rd(2'd3);
            n_checks++;
            if (rdata[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL glitch_capture inst%0d: got %h want 00000000", k, rdata[k]);
            end
        end
        n_checks++;
        if (irq_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_irq: got %b want 0", irq_v[0]);
        end
    endtask

    task automatic test_w1c;
        bit got = 0;
        in_port = '0;
        step(15);
        wr(2'd3, ALL);
        in_port = W'(32'h5);
        step(15);
        rd(2'd3);
        n_checks++;
        if (rdata[0] !== 32'h5) begin
            n_fail++;
            $display("FAIL w1c_setup: got %h want 00000005", rdata[0]);
        end
        wr(2'd3, 32'h4);
        rd(2'd3);
        n_checks++;
        if (rdata[0] !== 32'h1) begin
            n_fail++;
            $display("FAIL w1c_clear_bit2: got %h want 00000001", rdata[0]);
        end
        // Clear coinciding with a fresh bit2 event: the event must survive.
        in_port = W'(32'h1);
        step(15);
        wr(2'd3, ALL);
        in_port = W'(32'h5);
        for (int i = 0; i < 16 && !got; i++) begin
            step(1);
            rd(2'd0);
            if (rdata[0][2]) got = 1;
        end
        if (got) wr(2'd3, 32'h4);
        rd(2'd3);
        n_checks++;
        if (rdata[0] !== 32'h4) begin
            n_fail++;
            $display("FAIL w1c_event_wins: got %h want 00000004", rdata[0]);
        end
    endtask

    task automatic test_edge_types;
        logic [31:0] e [3];
        wr(2'd3, ALL);
        in_port = W'(32'h20005);
        step(20);
        e[0] = 32'h20000; e[1] = 32'h0; e[2] = 32'h20000;
        rd(2'd3);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rdata[k] !== e[k]) begin
                n_fail++;
                $display("FAIL edge_rise inst%0d: got %h want %h", k, rdata[k], e[k]);
            end
        end
        wr(2'd3, ALL);
        in_port = W'(32'h5);
        step(20);
        e[0] = 32'h0; e[1] = 32'h20000; e[2] = 32'h20000;
        rd(2'd3);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rdata[k] !== e[k]) begin
                n_fail++;
                $display("FAIL edge_fall inst%0d: got %h want %h", k, rdata[k], e[k]);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] v;
        logic [W-1:0] rs;
        logic [W-1:0] fl;
        logic [31:0]  d;
        int op;
        in_port = '0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        exp_deb = '0; exp_mask = '0;
        for (int k = 0; k < 3; k++) exp_cap[k] = '0;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: begin
                    v = W'($urandom);
                    in_port = v;
                    step($urandom_range(14, 25));
                    rs = v & ~exp_deb;
                    fl = ~v & exp_deb;
                    exp_cap[0] = exp_cap[0] | rs;
                    exp_cap[1] = exp_cap[1] | fl;
                    exp_cap[2] = exp_cap[2] | rs | fl;
                    exp_deb = v;
                end
                2: begin
                    in_port = exp_deb ^ W'($urandom);
                    step($urandom_range(1, 3));
                    in_port = exp_deb;
                    step($urandom_range(14, 20));
                end
                3: begin
                    d = $urandom;
                    wr(2'd2, d);
                    exp_mask = d[W-1:0];
                end
                4: begin
                    d = $urandom;
                    wr(2'd3, d);
                    for (int k = 0; k < 3; k++) exp_cap[k] = exp_cap[k] & ~d[W-1:0];
                end
                default: begin
                    wr(2'($urandom_range(0, 1)), $urandom);
                end
            endcase
            rd(2'd0);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (rdata[k] !== {14'h0, exp_deb}) begin
                    n_fail++;
                    $display("FAIL rand_data it%0d inst%0d: got %h want %h", it, k, rdata[k], exp_deb);
                end
            end
            rd(2'd1);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (rdata[k] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL rand_addr1 it%0d inst%0d: got %h want 00000000", it, k, rdata[k]);
                end
            end
            rd(2'd2);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (rdata[k] !== {14'h0, exp_mask}) begin
                    n_fail++;
                    $display("FAIL rand_mask it%0d inst%0d: got %h want %h", it, k, rdata[k], exp_mask);
                end
            end
            rd(2'd3);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (rdata[k] !== {14'h0, exp_cap[k]}) begin
                    n_fail++;
                    $display("FAIL rand_capture it%0d inst%0d: got %h want %h", it, k, rdata[k], exp_cap[k]);
                end
                n_checks++;
                if (irq_v[k] !== (|(exp_cap[k] & exp_mask))) begin
                    n_fail++;
                    $display("FAIL rand_irq it%0d inst%0d: got %b want %b", it, k, irq_v[k],
                             |(exp_cap[k] & exp_mask));
                end
            end
        end
    endtask

    task automatic test_reset_midcount;
        logic [31:0] e [3];
        in_port = '0;
        step(15);
        wr(2'd3, ALL);
        in_port = W'(32'h3);
        step(15);
        wr(2'd2, 32'h3);
        rd(2'd3);
        n_checks++;
        if (rdata[0] !== 32'h3) begin
            n_fail++;
            $display("FAIL rst_mid_setup_capture: got %h want 00000003", rdata[0]);
        end
        n_checks++;
        if (irq_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_setup_irq: got %b want 1", irq_v[0]);
        end
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (rdata[k] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL rst_mid_read inst%0d addr%0d: got %h want 00000000", k, a, rdata[k]);
                end
            end
        end
        n_checks++;
        if (irq_v !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_irq: got %b want 000", irq_v);
        end
        // Input held high through reset is seen as a fresh rising edge.
        step(15);
        e[0] = 32'h3; e[1] = 32'h0; e[2] = 32'h3;
        rd(2'd3);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rdata[k] !== e[k]) begin
                n_fail++;
                $display("FAIL rst_held_high inst%0d: got %h want %h", k, rdata[k], e[k]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_rise_detect;
        test_glitch;
        test_w1c;
        test_edge_types;
        test_random;
        test_reset_midcount;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
